// File: rtl/wb_trace_checker.sv
// rtl/wb_trace_checker.sv - golden-sequence writeback checker with optional PC trace buffer (WB_TRACE_BUF_EN)
module wb_trace_checker #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int EXP_DEPTH   = 64,
    parameter int TRACE_DEPTH = 16,
    parameter int TIMEOUT     = 500,
    localparam int IW = $clog2(EXP_DEPTH),
    localparam int CW = $clog2(EXP_DEPTH + 1),
    localparam int TW = $clog2(TRACE_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_wr_en,
    input  logic [DATA_W-1:0] exp_wr_data,
    input  logic              start,
    input  logic              wb_valid,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] wb_pc,
    input  logic [TW-1:0]     trace_rd_idx,
    output logic [ADDR_W-1:0] trace_rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic              exp_overflow,
    output logic [CW-1:0]     exp_count,
    output logic [CW-1:0]     retired_count,
    output logic [CW-1:0]     mismatch_count,
    output logic [IW-1:0]     first_fail_idx
);
    localparam int TOW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] mem [EXP_DEPTH];
    logic [TOW-1:0]    idle_cnt;

    logic              exp_full;
    logic              empty_run;
    logic              retire;
    logic              is_mismatch;
    logic              last_ret;
    logic              timeout_hit;
    logic [CW-1:0]     retired_inc;
    logic              run_clear;

    always_comb begin
        exp_full    = (exp_count == CW'(EXP_DEPTH));
        // Only reachable with an empty golden set: nothing to compare, finish at once.
        empty_run   = (retired_count == exp_count);
        retire      = (state == S_RUN) && wb_valid && !empty_run;
        is_mismatch = (wb_data != mem[retired_count[IW-1:0]]);
        retired_inc = retired_count + CW'(1);
        last_ret    = (retired_inc == exp_count);
        timeout_hit = !wb_valid && (idle_cnt == TOW'(TIMEOUT - 1));
        run_clear   = (state != S_RUN) && start;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN: begin
                if (empty_run)               state_next = S_DONE;
                else if (wb_valid && last_ret) state_next = S_DONE;
                else if (timeout_hit)        state_next = S_DONE;
            end
            S_DONE: if (start) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            pass           <= 1'b0;
            timed_out      <= 1'b0;
            exp_overflow   <= 1'b0;
            exp_count      <= '0;
            retired_count  <= '0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
            idle_cnt       <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && exp_wr_en) begin
                if (exp_full) exp_overflow <= 1'b1;
                else          exp_count    <= exp_count + CW'(1);
            end
            if (run_clear) begin
                pass           <= 1'b0;
                timed_out      <= 1'b0;
                retired_count  <= '0;
                mismatch_count <= '0;
                first_fail_idx <= '0;
                idle_cnt       <= '0;
            end else if (state == S_RUN) begin
                if (empty_run) begin
                    pass <= (mismatch_count == '0) && !timed_out;
                end else if (wb_valid) begin
                    retired_count <= retired_inc;
                    idle_cnt      <= '0;
                    if (is_mismatch) begin
                        mismatch_count <= mismatch_count + CW'(1);
                        if (mismatch_count == '0) first_fail_idx <= retired_count[IW-1:0];
                    end
                    if (last_ret) pass <= (mismatch_count == '0) && !is_mismatch;
                end else begin
                    idle_cnt <= idle_cnt + TOW'(1);
                    if (timeout_hit) begin
                        timed_out <= 1'b1;
                        pass      <= 1'b0;
                    end
                end
            end
        end
    end

    // Golden storage carries no reset so it can map onto block RAM; exp_count bounds validity.
    always_ff @(posedge clk) begin
        if (!reset && state == S_IDLE && exp_wr_en && !exp_full)
            mem[exp_count[IW-1:0]] <= exp_wr_data;
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

`ifdef WB_TRACE_BUF_EN
    logic [ADDR_W-1:0] trace_mem [TRACE_DEPTH];
    logic [TW-1:0]     trace_wptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
            trace_wptr <= '0;
        end else if (retire) begin
            trace_mem[trace_wptr] <= wb_pc;
            trace_wptr            <= trace_wptr + TW'(1);
        end
    end

    assign trace_rd_data = trace_mem[trace_wptr - TW'(1) - trace_rd_idx];
`else
    logic unused_trace;
    assign unused_trace  = ^{wb_pc, trace_rd_idx, retire};
    assign trace_rd_data = '0;
`endif
endmodule

// File: tb/tb_wb_trace_checker.sv
// tb/tb_wb_trace_checker.sv - scoreboard bench for wb_trace_checker (EXP_DEPTH=4, TRACE_DEPTH=4, TIMEOUT=10)
module tb_wb_trace_checker;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int ED = 4;
    localparam int TD = 4;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          reset, exp_wr_en, start, wb_valid;
    logic [DW-1:0] exp_wr_data, wb_data;
    logic [AW-1:0] wb_pc;
    logic [1:0]    trace_rd_idx;
    logic [AW-1:0] trace_rd_data;
    logic          busy, done, pass, timed_out, exp_overflow;
    logic [2:0]    exp_count, retired_count, mismatch_count;
    logic [1:0]    first_fail_idx;

    wb_trace_checker #(.DATA_W(DW), .ADDR_W(AW), .EXP_DEPTH(ED), .TRACE_DEPTH(TD), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .exp_wr_en(exp_wr_en), .exp_wr_data(exp_wr_data),
        .start(start), .wb_valid(wb_valid), .wb_data(wb_data), .wb_pc(wb_pc),
        .trace_rd_idx(trace_rd_idx), .trace_rd_data(trace_rd_data),
        .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
        .exp_overflow(exp_overflow), .exp_count(exp_count), .retired_count(retired_count),
        .mismatch_count(mismatch_count), .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ret;
        int mism;
        int ffi;
        bit fin;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] gold[$];
    logic [31:0] pcs[$];
    int          m_ret, m_mism, m_ffi;
    bit          m_ovf;
    int          checks = 0;
    int          failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        gold.delete();
        pcs.delete();
        m_ret = 0; m_mism = 0; m_ffi = 0; m_ovf = 1'b0;
    endtask

    task automatic load(input logic [31:0] v);
        exp_wr_en = 1'b1; exp_wr_data = v;
        tick();
        exp_wr_en = 1'b0;
        if (gold.size() < ED) gold.push_back(v);
        else m_ovf = 1'b1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_ret = 0; m_mism = 0; m_ffi = 0;
    endtask

    task automatic retire(input logic [31:0] d, input logic [31:0] pc);
        exp_t e, g;
        bit   mis;
        mis = (d != gold[m_ret]);
        if (mis && m_mism == 0) m_ffi = m_ret;
        if (mis) m_mism++;
        m_ret++;
        pcs.push_back(pc);
        e.ret = m_ret; e.mism = m_mism; e.ffi = m_ffi; e.fin = (m_ret == gold.size());
        sb.push_back(e);
        wb_valid = 1'b1; wb_data = d; wb_pc = pc;
        tick();
        wb_valid = 1'b0;
        g = sb.pop_front();
        checks++;
        if (int'(retired_count) !== g.ret) begin
            failures++; $display("FAIL retired_count got=%0d exp=%0d", retired_count, g.ret);
        end
        checks++;
        if (int'(mismatch_count) !== g.mism) begin
            failures++; $display("FAIL mismatch_count got=%0d exp=%0d", mismatch_count, g.mism);
        end
        checks++;
        if (done !== g.fin || busy !== !g.fin) begin
            failures++; $display("FAIL done_busy got=%b/%b exp=%b/%b", done, busy, g.fin, !g.fin);
        end
        if (g.mism != 0) begin
            checks++;
            if (int'(first_fail_idx) !== g.ffi) begin
                failures++; $display("FAIL first_fail_idx got=%0d exp=%0d", first_fail_idx, g.ffi);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, done, pass, timed_out, exp_overflow} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, pass, timed_out, exp_overflow});
        end
        checks++;
        if ({exp_count, retired_count, mismatch_count, first_fail_idx} !== 11'b0) begin
            failures++; $display("FAIL reset_counters got=%0h exp=0", {exp_count, retired_count, mismatch_count, first_fail_idx});
        end
        checks++;
        if (trace_rd_data !== 32'h0) begin
            failures++; $display("FAIL reset_trace got=%0h exp=0", trace_rd_data);
        end
    endtask

    task automatic test_match();
        logic [31:0] vals[4] = '{32'h5, 32'hA, 32'hF, 32'h14};
        do_reset();
        foreach (vals[i]) load(vals[i]);
        start_run();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL start_busy got=%b/%b exp=1/0", busy, done);
        end
        foreach (vals[i]) retire(vals[i], 32'h100 + 4 * i);
        checks++;
        if (pass !== (m_mism == 0)) begin
            failures++; $display("FAIL match_pass got=%b exp=%b", pass, m_mism == 0);
        end
    endtask

    task automatic test_mismatch();
        logic [31:0] vals[4] = '{32'h5, 32'hB, 32'hF, 32'h15};
        start_run();
        foreach (vals[i]) retire(vals[i], 32'h200 + 4 * i);
        checks++;
        if (pass !== (m_mism == 0) || exp_count !== 3'd4) begin
            failures++; $display("FAIL mismatch_pass got=%b/%0d exp=%b/4", pass, exp_count, m_mism == 0);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        load(32'h11); load(32'h22); load(32'h33);
        start_run();
        retire(32'h11, 32'h0);
        for (int i = 1; i <= TO; i++) begin
            tick();
            checks++;
            if (done !== (i == TO)) begin
                failures++; $display("FAIL timeout_done cycle=%0d got=%b exp=%b", i, done, i == TO);
            end
        end
        checks++;
        if (timed_out !== 1'b1 || pass !== 1'b0 || int'(retired_count) !== m_ret) begin
            failures++; $display("FAIL timeout_state got=%b/%b/%0d exp=1/0/%0d", timed_out, pass, retired_count, m_ret);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) load(32'h40 + i);
        checks++;
        if (int'(exp_count) !== gold.size() || exp_overflow !== m_ovf) begin
            failures++; $display("FAIL overflow got=%0d/%b exp=%0d/%b", exp_count, exp_overflow, gold.size(), m_ovf);
        end
        do_reset();
        start_run();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL empty_enter got=%b/%b exp=1/0", busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL empty_done got=%b/%b/%b exp=1/1/0", done, pass, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        for (int i = 0; i < 4; i++) load(32'h70 + i);
        start_run();
        retire(32'h70, 32'h0);
        retire(32'h99, 32'h4);
        do_reset();
        checks++;
        if ({busy, done, pass, timed_out, exp_overflow, exp_count, retired_count, mismatch_count, first_fail_idx} !== '0) begin
            failures++; $display("FAIL midrun_reset got=%0h exp=0",
                {busy, done, pass, timed_out, exp_overflow, exp_count, retired_count, mismatch_count, first_fail_idx});
        end
        wb_valid = 1'b1; wb_data = 32'h70;
        tick();
        wb_valid = 1'b0;
        checks++;
        if (retired_count !== 3'd0 || mismatch_count !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL idle_wb got=%0d/%0d/%b exp=0/0/0", retired_count, mismatch_count, busy);
        end
    endtask

    task automatic test_trace();
        logic [31:0] expv;
        do_reset();
        for (int i = 0; i < 4; i++) load(32'h80 + i);
        start_run();
        for (int i = 0; i < 4; i++) retire(32'h80 + i, 32'(4 * i));
        start_run();
        for (int i = 4; i < 6; i++) retire(32'h80 + i - 4, 32'(4 * i));
        for (int k = 0; k < TD; k++) begin
            trace_rd_idx = 2'(k);
            #1;
`ifdef WB_TRACE_BUF_EN
            expv = pcs[pcs.size() - 1 - k];
`else
            expv = 32'h0;
`endif
            checks++;
            if (trace_rd_data !== expv) begin
                failures++; $display("FAIL trace idx=%0d got=%0h exp=%0h", k, trace_rd_data, expv);
            end
        end
    endtask

    initial begin
        reset = 1'b0; exp_wr_en = 1'b0; exp_wr_data = '0; start = 1'b0;
        wb_valid = 1'b0; wb_data = '0; wb_pc = '0; trace_rd_idx = '0;
        test_reset();
        test_match();
        test_mismatch();
        test_timeout();
        test_overflow();
        test_reset_mid_run();
        test_trace();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Self-checking writeback monitor for the pipelined RISC-V core: it holds a golden sequence of expected writeback values, compares each retired writeback from the core against it in order, and reports pass/fail, mismatch statistics and timeout. It replaces hand-inspection of `WB_Data` in the top-level bench with a parametrised, synthesizable checker. It can also be instantiated in FPGA builds. An optional circular trace buffer records the PCs of the most recent retirements for post-mortem debug.

## Interface
Parameters:
- `DATA_W`, 32: writeback data width.
- `ADDR_W`, 32: PC width.
- `EXP_DEPTH`, 64: golden-memory entries; power of two, ≥2.
- `TRACE_DEPTH`, 16: trace-buffer entries; power of two, ≥2.
- `TIMEOUT`, 500: maximum idle cycles between retirements in RUN; ≥1.

Ports (clock and reset first; `IW`=$clog2(EXP_DEPTH), `CW`=$clog2(EXP_DEPTH+1), `TW`=$clog2(TRACE_DEPTH)):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `exp_wr_en` in 1: append `exp_wr_data` to golden memory (IDLE only).
- `exp_wr_data` in DATA_W: golden value.
- `start` in 1: begin or restart a check run.
- `wb_valid` in 1: core retired a register writeback this cycle.
- `wb_data` in DATA_W: retired writeback value.
- `wb_pc` in ADDR_W: PC of retiring instruction.
- `trace_rd_idx` in TW: 0 = newest entry, 1 = previous, and so on.
- `trace_rd_data` out ADDR_W: combinational read of the trace buffer.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `pass` out 1: valid when `done`.
- `timed_out` out 1: run ended by timeout.
- `exp_overflow` out 1: sticky; a golden write was dropped because memory was full.
- `exp_count` out CW: number of golden entries loaded.
- `retired_count` out CW: writebacks compared in the current run.
- `mismatch_count` out CW: compare failures in the current run.
- `first_fail_idx` out IW: index of the first mismatch; meaningful only when `mismatch_count`≠0.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**:
  - `exp_wr_en` writes `mem[exp_count]` and increments `exp_count`.
  - If `exp_count`==EXP_DEPTH, the write is dropped and `exp_overflow` is set.
  - `wb_valid` is ignored.
  - `start` moves to RUN and clears `retired_count`, `mismatch_count`, `first_fail_idx`, `timed_out` and the timeout counter.
- **RUN**:
  - On `wb_valid`, compare `wb_data` with `mem[retired_count]`.
  - On inequality, increment `mismatch_count`; if it was 0, latch `first_fail_idx`=`retired_count`.
  - Increment `retired_count` and clear the timeout counter.
  - When the post-increment `retired_count` equals `exp_count`, go to DONE.
  - Without `wb_valid`, the timeout counter increments; on reaching TIMEOUT, go to DONE with `timed_out`=1.
  - `exp_wr_en` and `start` are ignored in RUN.
- **Empty golden set**: `start` with `exp_count`==0 enters RUN, then DONE on the next edge with `pass`=1.
- **DONE**:
  - `pass` = (`mismatch_count`==0) && !`timed_out`.
  - `wb_valid` is ignored.
  - `start` re-enters RUN with counters cleared; golden contents and `exp_count` are kept.
- **Simultaneous events in RUN**: if `wb_valid` and timeout-threshold occur on the same edge, the retirement wins and the timeout counter is cleared.
- All counters are unsigned. None can exceed EXP_DEPTH, so they never wrap.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `pass`, `timed_out`, `exp_overflow` = 0.
  - All counters and `first_fail_idx` = 0.
  - Trace buffer contents = 0.
  - `trace_rd_data` = 0.
- Reset mid-run returns to IDLE on that edge and discards all golden entries.
- All outputs except `trace_rd_data` are registered.
- A `wb_valid` sampled at edge N is reflected in the counters after edge N.
- If that retirement is the last one, `done`=1 and `busy`=0 after edge N.
- `start` sampled at edge N gives `busy`=1 after edge N.
- Timeout is reached at edge N, where N is the TIMEOUT-th consecutive RUN cycle without `wb_valid`; `done` is set after that edge.
- Golden memory is written synchronously; a write at edge N is readable for compare from edge N+1.

## Configuration
- `WB_TRACE_BUF_EN` defined:
  - On every RUN `wb_valid`, `wb_pc` is written into a TRACE_DEPTH circular buffer; the write pointer wraps modulo TRACE_DEPTH.
  - `trace_rd_data` = entry at (wptr−1−`trace_rd_idx`) mod TRACE_DEPTH.
  - The buffer is not cleared by `start`, only by `reset`.
- Macro undefined: no trace storage is built and `trace_rd_data` is tied to 0.

## Test plan
- Load 4 golden values {0x5, 0xA, 0xF, 0x14}, `start`, retire the same 4 → `done`=1 one edge after the 4th, `pass`=1, `retired_count`=4, `mismatch_count`=0.
- Same golden set, retire {0x5, 0xB, 0xF, 0x15} → `pass`=0, `mismatch_count`=2, `first_fail_idx`=1.
- TIMEOUT=10, load 3 values, retire 1, then idle → `done` and `timed_out`=1 exactly 10 cycles after the retirement edge, `pass`=0, `retired_count`=1.
- EXP_DEPTH=4, issue 5 writes → `exp_count`=4, `exp_overflow`=1; then `start` with no writes after a reset → `done`=1, `pass`=1 one edge after entering RUN.
- Assert `reset` mid-RUN after 2 retirements → all outputs are 0 after that edge; `exp_count`=0; `wb_valid` in IDLE leaves counters at 0.
- With `WB_TRACE_BUF_EN`, TRACE_DEPTH=4, retire 6 with PCs 0x0, 0x4, …, 0x14 → `trace_rd_idx`=0 gives 0x14 and `trace_rd_idx`=3 gives 0x8; without the macro, `trace_rd_data`=0.
